me_run_ctrl: RTL

ME_RUN_CTRL -- requirements
Module: me_run_ctrl

---
 rtl/me_run_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/me_run_ctrl.sv
// Motion-estimation run controller: debounced pushbuttons drive a req/ack handshake
// with the search engine and keep a ring of captured results for display paging.
`timescale 1ns/1ps
module me_run_ctrl #(
  parameter int unsigned CNT_WIDTH      = 12,
  parameter int unsigned SAD_WIDTH      = 16,
  parameter int unsigned HIST_DEPTH     = 8,
  parameter int unsigned DB_CYCLES      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_n,
  input  logic                          abort_n,
  input  logic                          page_n,
  output logic                          req,
  input  logic                          ack,
  input  logic [CNT_WIDTH-1:0]          min_cnt,
  input  logic [SAD_WIDTH-1:0]          min_sad,
  input  logic [CNT_WIDTH-1:0]          min_mvec,
  output logic [CNT_WIDTH-1:0]          disp_cnt,
  output logic [SAD_WIDTH-1:0]          disp_sad,
  output logic [CNT_WIDTH-1:0]          disp_mvec,
  output logic [$clog2(HIST_DEPTH)-1:0] disp_idx,
  output logic [15:0]                   run_count,
  output logic                          busy,
  output logic                          timeout_err,
  output logic                          hist_full
);

  localparam int unsigned IDX_W = $clog2(HIST_DEPTH);
  localparam int unsigned DB_W  = $clog2(DB_CYCLES);
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_CAPTURE, S_RELEASE} state_t;

  // Reset asserts immediately, releases two clocks after rst falls
  logic [1:0] rst_pipe;
  logic       rst_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe <= 2'b11;
    else     rst_pipe <= {rst_pipe[0], 1'b0};
  end

  assign rst_i = rst_pipe[1];

  logic [2:0] btn_n;
  logic [2:0] press;
  logic       start_p, abort_p, page_p;

  assign btn_n   = {page_n, abort_n, start_n};
  assign start_p = press[0];
  assign abort_p = press[1];
  assign page_p  = press[2];

  for (genvar g = 0; g < 3; g++) begin : g_btn
    logic            s1, s2, stable, pulse;
    logic [DB_W-1:0] cnt;

    // cnt tracks consecutive samples disagreeing with the stable level
    always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
        s1     <= 1'b1;
        s2     <= 1'b1;
        stable <= 1'b1;
        pulse  <= 1'b0;
        cnt    <= '0;
      end else begin
        s1    <= btn_n[g];
        s2    <= s1;
        pulse <= 1'b0;
        if (s2 == stable) begin
          cnt <= '0;
        end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
          cnt    <= '0;
          stable <= s2;
          pulse  <= stable;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign press[g] = pulse;
  end

  state_t          state, state_d;
  logic            req_d, busy_d, to_err_d;
  logic            timeout_hit_c, capture_c;
  logic [TO_W-1:0] tcnt;

  assign timeout_hit_c = (tcnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign capture_c     = (state == S_CAPTURE);

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      req         <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      req         <= req_d;
      busy        <= busy_d;
      timeout_err <= to_err_d;
    end
  end

  // Ack beats a coincident abort, abort beats the timeout
  always_comb begin
    state_d  = state;
    to_err_d = timeout_err;
    case (state)
      S_IDLE:    if (start_p) state_d = S_REQ;
      S_REQ: begin
        if (ack) begin
          state_d = S_CAPTURE;
        end else if (abort_p) begin
          state_d = S_RELEASE;
        end else if (timeout_hit_c) begin
          state_d  = S_RELEASE;
          to_err_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d  = S_RELEASE;
        to_err_d = 1'b0;
      end
      S_RELEASE: if (!ack) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    req_d  = (state_d == S_REQ) || (state_d == S_CAPTURE);
    busy_d = (state_d != S_IDLE);
  end

  logic [CNT_WIDTH-1:0] hist_cnt  [HIST_DEPTH];
  logic [SAD_WIDTH-1:0] hist_sad  [HIST_DEPTH];
  logic [CNT_WIDTH-1:0] hist_mvec [HIST_DEPTH];
  logic [IDX_W-1:0]     wr_ptr;

  // History ring, pointers and run bookkeeping; capture overrides paging
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      hist_cnt  <= '{default: '0};
      hist_sad  <= '{default: '0};
      hist_mvec <= '{default: '0};
      wr_ptr    <= '0;
      disp_idx  <= '0;
      run_count <= '0;
      hist_full <= 1'b0;
      tcnt      <= '0;
    end else begin
      tcnt <= (state == S_REQ) ? tcnt + 1'b1 : '0;
      if (capture_c) begin
        hist_cnt[wr_ptr]  <= min_cnt;
        hist_sad[wr_ptr]  <= min_sad;
        hist_mvec[wr_ptr] <= min_mvec;
        wr_ptr            <= wr_ptr + 1'b1;
        disp_idx          <= wr_ptr;
        run_count         <= run_count + 16'd1;
        if (wr_ptr == IDX_W'(HIST_DEPTH - 1)) hist_full <= 1'b1;
      end else if (page_p) begin
        disp_idx <= disp_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      disp_cnt  <= '0;
      disp_sad  <= '0;
      disp_mvec <= '0;
    end else begin
      disp_cnt  <= hist_cnt[disp_idx];
      disp_sad  <= hist_sad[disp_idx];
      disp_mvec <= hist_mvec[disp_idx];
    end
  end

endmodule
